// File: rtl/tqvp_rejunity_vga_flip_ctrl.sv
// Page-flip and raster-event scheduler for the double-banked 1-bpp VGA framebuffer.
// Bank swaps are committed only at frame start; also provides a raster-line IRQ and frame counter.
module tqvp_rejunity_vga_flip_ctrl #(
   parameter int Y_BITS         = 10,
   parameter int FRAME_CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [5:0]          address,
   input  logic [31:0]         data_in,
   input  logic [1:0]          data_write_n,
   input  logic [1:0]          data_read_n,
   output logic [31:0]         data_out,
   output logic                data_ready,
   input  logic                frame_start,
   input  logic                line_start,
   input  logic [Y_BITS-1:0]   y,
   output logic                display_bank,
   output logic                write_bank,
   output logic                flip_pending,
   output logic                interrupt
);

   typedef enum logic [1:0] {IDLE, ARMED, COMMIT} state_t;

   localparam logic [FRAME_CNT_BITS-1:0] FC_ONE = 1;

   state_t                    state_q;
   logic                      disp_bank_q;
   logic                      flip_flag_q;
   logic                      raster_flag_q;
   logic                      flip_en_q;
   logic                      raster_en_q;
   logic [9:0]                raster_line_q;
   logic [7:0]                auto_period_q;
   logic [7:0]                auto_cnt_q;
   logic [FRAME_CNT_BITS-1:0] frame_cnt_q;
   logic                      irq_q;

   logic        wr_d, byte_wr_d;
   logic        ctrl_wr_d, raster_wr_d, period_wr_d, status_wr_d;
   logic        auto_req_d, req_d, commit_d, raster_hit_d;
   logic [31:0] rdata_d;
   logic        unused_data;

   assign wr_d        = (data_write_n != 2'b11);
   assign byte_wr_d   = (data_write_n == 2'b00);
   assign ctrl_wr_d   = wr_d && (address == 6'h38);
   assign raster_wr_d = wr_d && (address == 6'h39);
   assign period_wr_d = wr_d && (address == 6'h3A);
   assign status_wr_d = wr_d && (address == 6'h3B);

   // A period write restarts the auto sequence, so it suppresses a coincident auto request.
   assign auto_req_d   = frame_start && !period_wr_d && (auto_period_q != 8'd0) &&
                         ((auto_cnt_q + 8'd1) == auto_period_q);
   assign req_d        = (ctrl_wr_d && data_in[0]) || auto_req_d;
   assign commit_d     = (state_q == ARMED) && frame_start;
   assign raster_hit_d = line_start && (32'(y) == 32'(raster_line_q));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         disp_bank_q   <= 1'b0;
         flip_flag_q   <= 1'b0;
         raster_flag_q <= 1'b0;
         flip_en_q     <= 1'b0;
         raster_en_q   <= 1'b0;
         raster_line_q <= 10'd0;
         auto_period_q <= 8'd0;
         auto_cnt_q    <= 8'd0;
         frame_cnt_q   <= '0;
         irq_q         <= 1'b0;
      end else begin
         if (ctrl_wr_d) begin
            flip_en_q   <= data_in[1];
            raster_en_q <= data_in[2];
         end

         if (raster_wr_d)
            raster_line_q <= byte_wr_d ? {2'b00, data_in[7:0]} : data_in[9:0];

         if (period_wr_d) begin
            auto_period_q <= data_in[7:0];
            auto_cnt_q    <= 8'd0;
         end else if (frame_start && (auto_period_q != 8'd0)) begin
            auto_cnt_q <= auto_req_d ? 8'd0 : auto_cnt_q + 8'd1;
         end

         if (frame_start)
            frame_cnt_q <= frame_cnt_q + FC_ONE;

         // Requests outside IDLE are dropped; there is no queue.
         case (state_q)
            IDLE:    if (req_d) state_q <= ARMED;
            ARMED:   if (frame_start) begin
                        state_q     <= COMMIT;
                        disp_bank_q <= ~disp_bank_q;
                     end
            COMMIT:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase

         if (commit_d)
            flip_flag_q <= 1'b1;
         else if (status_wr_d && data_in[3])
            flip_flag_q <= 1'b0;

         if (raster_hit_d)
            raster_flag_q <= 1'b1;
         else if (status_wr_d && data_in[2])
            raster_flag_q <= 1'b0;

         irq_q <= (flip_flag_q & flip_en_q) | (raster_flag_q & raster_en_q);
      end
   end

   always_comb begin
      rdata_d = 32'd0;
      case (address)
         6'h3B:   rdata_d = {28'd0, flip_flag_q, raster_flag_q, disp_bank_q, (state_q != IDLE)};
         6'h3C:   rdata_d = 32'(frame_cnt_q);
         default: rdata_d = 32'd0;
      endcase
   end

   assign data_out     = (data_read_n != 2'b11) ? rdata_d : 32'd0;
   assign data_ready   = 1'b1;
   assign display_bank = disp_bank_q;
   assign write_bank   = ~disp_bank_q;
   assign flip_pending = (state_q != IDLE);
   assign interrupt    = irq_q;
   assign unused_data  = ^data_in[31:10];

endmodule
